msrv32_fetch_queue: RTL and testbench
=====================================

MSRV32_FETCH_QUEUE -- requirements
Module: msrv32_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of instruction entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter NOP_INSTR, default 32'h00000013, word presented when no valid instruction is held.
REQ-003 The block SHALL run on one clock, and its reset SHALL be synchronous and active-low.
REQ-004 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  synchronous, active-low reset.
REQ-006 imem_valid_in  input  1  instruction memory response valid.
REQ-007 imem_instr_in  input  32  fetched instruction word.
REQ-008 imem_pc_in  input  32  address of the fetched word.
REQ-009 imem_ready_out  output  1  queue can accept a response this cycle.
REQ-010 flush_in  input  1  branch/trap redirect; discard all held and incoming words.
REQ-011 stall_in  input  1  downstream decode not consuming this cycle.
REQ-012 instr_out  output  32  head instruction, feeds the instruction mux instr_in.
REQ-013 pc_out  output  32  address of head instruction.
REQ-014 instr_valid_out  output  1  instr_out/pc_out hold a real queued entry.
REQ-015 flush_out  output  1  drives instruction mux flush_in (NOP injection).
REQ-016 count_out  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH {instr, pc} pairs with write pointer, read pointer and occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-018 imem_ready_out SHALL be combinational: 1 when count < DEPTH, else 0; independent of flush_in and stall_in.
REQ-019 Push SHALL occur when imem_valid_in & imem_ready_out & !flush_in: entry written at write pointer, write pointer +1.
REQ-020 Pop SHALL occur when instr_valid_out & !stall_in & !flush_in: read pointer +1.
REQ-021 count next = count + push - pop; simultaneous push and pop SHALL leave count unchanged.
REQ-022 instr_valid_out SHALL be 1 exactly when count != 0.
REQ-023 When count != 0, instr_out/pc_out SHALL show the entry at the read pointer combinationally; when count == 0, instr_out = NOP_INSTR, pc_out = 0.
REQ-024 flush_out SHALL equal flush_in | (count == 0).
REQ-025 No bypass: a word pushed in cycle N SHALL first appear on instr_out in cycle N+1 (minimum latency 1 cycle); push into empty queue never pops same cycle.
REQ-026 flush_in = 1 SHALL, at the next edge, set count to 0 and both pointers to 0; a response presented in the flush cycle SHALL be dropped; no pop in that cycle.
REQ-027 flush_in has priority over push, pop and stall; reset has priority over flush.
REQ-028 Full (count == DEPTH): imem_valid_in SHALL be ignored and no entry overwritten; a pop in that cycle frees space visible as imem_ready_out = 1 the following cycle.
REQ-029 Empty: stall_in has no effect; pop never occurs, count never underflows.
REQ-030 Entries SHALL leave in exact push order; pc_out always paired with its own instruction.

Reset
REQ-031 While rst_in = 0 at a rising edge: count, read and write pointers SHALL become 0; storage contents need not be cleared.
REQ-032 After reset: instr_valid_out = 0, flush_out = 1, instr_out = 32'h00000013, pc_out = 0, count_out = 0, imem_ready_out = 1.
REQ-033 Reset asserted mid-operation (queue partially full, push or pop pending) SHALL discard all entries and pending transfers identically to REQ-031.

Verification
REQ-034 Reset, then push instr 32'h00500093 pc 32'h0 with stall_in = 0 -> next cycle instr_out = 32'h00500093, pc_out = 0, instr_valid_out = 1, flush_out = 0; following cycle empty, instr_out = 32'h00000013.
REQ-035 stall_in = 1, push 5 words with DEPTH = 4 -> count_out = 4, imem_ready_out = 0 after 4th; 5th word dropped; release stall -> words 1..4 drain in order, pcs 0,4,8,12.
REQ-036 Queue holding 3 entries, flush_in = 1 with imem_valid_in = 1 -> next cycle count_out = 0, flush_out = 1, instr_out = 32'h00000013; flush-cycle word never appears.
REQ-037 Full queue, stall_in = 0 and imem_valid_in = 1 -> one pop, no push that cycle; next cycle count_out = 3, imem_ready_out = 1; wrap-around of both pointers checked over 10 continuous push/pop cycles.
REQ-038 Queue holding 2 entries, rst_in = 0 for one cycle with push and pop asserted -> count_out = 0, instr_valid_out = 0, flush_out = 1, imem_ready_out = 1.

Source files
------------

// File: rtl/msrv32_fetch_queue.sv
// rtl/msrv32_fetch_queue.sv - instruction fetch queue between imem responses and the decode stage
module msrv32_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       imem_valid_in,
  input  logic [31:0]                imem_instr_in,
  input  logic [31:0]                imem_pc_in,
  output logic                       imem_ready_out,
  input  logic                       flush_in,
  input  logic                       stall_in,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic                       instr_valid_out,
  output logic                       flush_out,
  output logic [$clog2(DEPTH):0]     count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_ready;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;

  always_comb begin
    w_ready = (r_count != CW'(DEPTH));
    w_valid = (r_count != '0);
    w_push  = imem_valid_in & w_ready & ~flush_in;
    w_pop   = w_valid & ~stall_in & ~flush_in;
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in) begin
    if (!rst_in || flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // Storage is deliberately not reset; occupancy alone defines validity.
  always_ff @(posedge clk_in) begin
    if (rst_in && w_push) begin
      r_instr_mem[r_wr_ptr] <= imem_instr_in;
      r_pc_mem[r_wr_ptr]    <= imem_pc_in;
    end
  end

  always_comb begin
    imem_ready_out  = w_ready;
    instr_valid_out = w_valid;
    count_out       = r_count;
    flush_out       = flush_in | ~w_valid;
    instr_out       = w_valid ? r_instr_mem[r_rd_ptr] : NOP_INSTR;
    pc_out          = w_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
  end

endmodule

// File: tb/tb_msrv32_fetch_queue.sv
// tb/tb_msrv32_fetch_queue.sv - directed bench for msrv32_fetch_queue (DEPTH = 4)
module tb_msrv32_fetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        imem_valid_in;
  logic [31:0] imem_instr_in;
  logic [31:0] imem_pc_in;
  logic        imem_ready_out;
  logic        flush_in;
  logic        stall_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid_out;
  logic        flush_out;
  logic [2:0]  count_out;

  int checks   = 0;
  int failures = 0;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];

  msrv32_fetch_queue #(.DEPTH(4), .NOP_INSTR(32'h00000013)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .imem_valid_in   (imem_valid_in),
    .imem_instr_in   (imem_instr_in),
    .imem_pc_in      (imem_pc_in),
    .imem_ready_out  (imem_ready_out),
    .flush_in        (flush_in),
    .stall_in        (stall_in),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .instr_valid_out (instr_valid_out),
    .flush_out       (flush_out),
    .count_out       (count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] instr, input logic [31:0] pc);
    imem_valid_in = 1'b1;
    imem_instr_in = instr;
    imem_pc_in    = pc;
    tick();
    imem_valid_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; imem_valid_in = 1'b0; imem_instr_in = '0; imem_pc_in = '0;
    flush_in = 1'b0; stall_in = 1'b0;
    tick(); tick();
    rst_in = 1'b1;

    chk("rst_valid", {31'b0, instr_valid_out}, 32'd0);
    chk("rst_flush", {31'b0, flush_out}, 32'd1);
    chk("rst_instr", instr_out, 32'h00000013);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_count", {29'b0, count_out}, 32'd0);
    chk("rst_ready", {31'b0, imem_ready_out}, 32'd1);

    tick();
    chk("empty_no_underflow", {29'b0, count_out}, 32'd0);

    // single word, one-cycle latency then drained
    push_word(32'h00500093, 32'h0);
    chk("one_instr", instr_out, 32'h00500093);
    chk("one_pc", pc_out, 32'h0);
    chk("one_valid", {31'b0, instr_valid_out}, 32'd1);
    chk("one_flush", {31'b0, flush_out}, 32'd0);
    tick();
    chk("one_drained_instr", instr_out, 32'h00000013);
    chk("one_drained_valid", {31'b0, instr_valid_out}, 32'd0);

    // fill while stalled, fifth word dropped
    stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", {31'b0, imem_ready_out}, (i < 4) ? 32'd1 : 32'd0);
      push_word(32'h100 + i, 32'(4 * i));
    end
    chk("full_count", {29'b0, count_out}, 32'd4);
    chk("full_ready", {31'b0, imem_ready_out}, 32'd0);
    stall_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_instr", instr_out, 32'h100 + i);
      chk("drain_pc", pc_out, 32'(4 * i));
      tick();
    end
    chk("drain_empty", {29'b0, count_out}, 32'd0);

    // flush with an incoming word
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'h200 + i, 32'h40 + 32'(4 * i));
    chk("pre_flush_count", {29'b0, count_out}, 32'd3);
    flush_in = 1'b1; imem_valid_in = 1'b1; imem_instr_in = 32'hDEAD0001; imem_pc_in = 32'h99;
    #1;
    chk("flush_out_comb", {31'b0, flush_out}, 32'd1);
    tick();
    flush_in = 1'b0; imem_valid_in = 1'b0;
    chk("post_flush_count", {29'b0, count_out}, 32'd0);
    chk("post_flush_flush", {31'b0, flush_out}, 32'd1);
    chk("post_flush_instr", instr_out, 32'h00000013);
    tick();
    chk("flush_word_dropped", {29'b0, count_out}, 32'd0);

    // full queue: pop but no push, then continuous streaming through wrap
    for (int i = 0; i < 4; i++) push_word(32'h300 + i, 32'h80 + 32'(4 * i));
    chk("full2_count", {29'b0, count_out}, 32'd4);
    stall_in = 1'b0;
    push_word(32'h00000BAD, 32'hFC);
    chk("full_pop_count", {29'b0, count_out}, 32'd3);
    chk("full_pop_ready", {31'b0, imem_ready_out}, 32'd1);
    chk("full_pop_head", instr_out, 32'h301);
    q_instr = '{32'h301, 32'h302, 32'h303};
    q_pc    = '{32'h84, 32'h88, 32'h8C};
    for (int k = 0; k < 10; k++) begin
      chk("stream_instr", instr_out, q_instr[0]);
      chk("stream_pc", pc_out, q_pc[0]);
      void'(q_instr.pop_front());
      void'(q_pc.pop_front());
      q_instr.push_back(32'h400 + k);
      q_pc.push_back(32'h100 + 32'(4 * k));
      push_word(32'h400 + k, 32'h100 + 32'(4 * k));
      chk("stream_count", {29'b0, count_out}, 32'd3);
    end
    for (int k = 0; k < 3; k++) begin
      chk("tail_instr", instr_out, 32'h407 + k);
      chk("tail_pc", pc_out, 32'h11C + 32'(4 * k));
      tick();
    end
    chk("tail_empty", {29'b0, count_out}, 32'd0);

    // reset mid-operation with push and pop pending
    stall_in = 1'b1;
    push_word(32'h500, 32'h200);
    push_word(32'h501, 32'h204);
    chk("pre_rst_count", {29'b0, count_out}, 32'd2);
    stall_in = 1'b0; rst_in = 1'b0;
    imem_valid_in = 1'b1; imem_instr_in = 32'h502; imem_pc_in = 32'h208;
    tick();
    rst_in = 1'b1; imem_valid_in = 1'b0;
    chk("mid_rst_count", {29'b0, count_out}, 32'd0);
    chk("mid_rst_valid", {31'b0, instr_valid_out}, 32'd0);
    chk("mid_rst_flush", {31'b0, flush_out}, 32'd1);
    chk("mid_rst_ready", {31'b0, imem_ready_out}, 32'd1);
    chk("mid_rst_instr", instr_out, 32'h00000013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
